// File: rtl/l1_dm_cache_if.sv
// CPU-side word bus and memory-side line bus of the L1 cache, bundled for one port.
// valid/ready: mem_read/mem_write are held until a one-cycle mem_resp; pmem_read/pmem_write are held until a one-cycle pmem_resp.
interface l1_dm_cache_if;
   logic [31:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;
   logic         mem_resp;
   logic [31:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   // master is the environment (CPU + physical memory), slave is the cache
   modport master (
      output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      output pmem_rdata, pmem_resp,
      input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
   );
   modport slave (
      input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      input  pmem_rdata, pmem_resp,
      output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
   );
endinterface

// File: rtl/l1_dm_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache with flop-based tag/data arrays.
// Moves whole 256-bit lines to physical memory; o_state exposes the controller state.
module l1_dm_cache #(
   parameter int  S_INDEX  = 3,
   localparam int S_OFFSET = 5,
   localparam int S_TAG    = 32 - S_OFFSET - S_INDEX
) (
   input  logic                clk,
   input  logic                rst,
   l1_dm_cache_if.slave        io_bus,
   output logic [1:0]          o_state
);
   localparam int N_SETS = 2 ** S_INDEX;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      TAG_CHECK = 2'd1,
      WRITEBACK = 2'd2,
      ALLOCATE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;

   logic [N_SETS-1:0]   r_valid;
   logic [N_SETS-1:0]   r_dirty;
   logic [S_TAG-1:0]    r_tag  [N_SETS];
   logic [255:0]        r_data [N_SETS];

   logic [31:0]         r_addr;
   logic [31:0]         r_wdata;
   logic [3:0]          r_be;
   logic                r_is_write;

   logic [S_TAG-1:0]    w_tag;
   logic [S_INDEX-1:0]  w_index;
   logic [2:0]          w_word;
   logic [255:0]        w_line;
   logic [255:0]        w_merged;
   logic                w_hit;

   assign w_tag   = r_addr[31:S_OFFSET+S_INDEX];
   assign w_index = r_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
   assign w_word  = r_addr[4:2];
   assign w_line  = r_data[w_index];
   assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign o_state = r_state;

   always_comb begin
      w_merged = w_line;
      for (int b = 0; b < 4; b++) begin
         if (r_be[b]) w_merged[w_word*32 + b*8 +: 8] = r_wdata[b*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // The request is captured once in IDLE; later states only use the latched copy
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
         r_is_write <= 1'b0;
      end else if (r_state == IDLE && (io_bus.mem_read || io_bus.mem_write)) begin
         r_addr     <= io_bus.mem_address;
         r_wdata    <= io_bus.mem_wdata;
         r_be       <= io_bus.mem_byte_enable;
         r_is_write <= io_bus.mem_write;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (r_state == TAG_CHECK && w_hit && r_is_write) begin
         r_dirty[w_index] <= 1'b1;
      end else if (r_state == ALLOCATE && io_bus.pmem_resp) begin
         r_valid[w_index] <= 1'b1;
         r_dirty[w_index] <= 1'b0;
      end
   end

   // Tag and data arrays carry no reset; valid bits alone qualify them
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == ALLOCATE && io_bus.pmem_resp) begin
            r_tag[w_index]  <= w_tag;
            r_data[w_index] <= io_bus.pmem_rdata;
         end else if (r_state == TAG_CHECK && w_hit && r_is_write) begin
            r_data[w_index] <= w_merged;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (io_bus.mem_read || io_bus.mem_write) w_next = TAG_CHECK;
         TAG_CHECK: begin
            if (w_hit)                                    w_next = IDLE;
            else if (r_valid[w_index] && r_dirty[w_index]) w_next = WRITEBACK;
            else                                          w_next = ALLOCATE;
         end
         WRITEBACK: if (io_bus.pmem_resp) w_next = ALLOCATE;
         ALLOCATE:  if (io_bus.pmem_resp) w_next = TAG_CHECK;
         default:   w_next = IDLE;
      endcase
   end

   always_comb begin
      io_bus.mem_rdata    = '0;
      io_bus.mem_resp     = 1'b0;
      io_bus.pmem_address = '0;
      io_bus.pmem_read    = 1'b0;
      io_bus.pmem_write   = 1'b0;
      io_bus.pmem_wdata   = '0;
      case (r_state)
         TAG_CHECK: begin
            if (w_hit) begin
               io_bus.mem_resp  = 1'b1;
               io_bus.mem_rdata = w_line[w_word*32 +: 32];
            end
         end
         WRITEBACK: begin
            io_bus.pmem_write   = 1'b1;
            io_bus.pmem_address = {r_tag[w_index], w_index, 5'b00000};
            io_bus.pmem_wdata   = w_line;
         end
         ALLOCATE: begin
            io_bus.pmem_read    = 1'b1;
            io_bus.pmem_address = {w_tag, w_index, 5'b00000};
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_l1_dm_cache.sv
// Directed bench for l1_dm_cache: hits, clean/dirty misses, write merge and reset abort.
module tb_l1_dm_cache;
   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;
   int         tests;
   int         fails;

   l1_dm_cache_if bus ();

   l1_dm_cache dut (
      .clk     (clk),
      .rst     (rst),
      .io_bus  (bus),
      .o_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] mk_line(input logic [31:0] base);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
      return l;
   endfunction

   // One CPU access; memory answers each pmem request in the cycle it is seen
   task automatic access(
      input string        tag,
      input logic [31:0]  addr,
      input bit           wr,
      input logic [3:0]   be,
      input logic [31:0]  wd,
      input bit           exp_wb,
      input logic [31:0]  wb_addr,
      input logic [255:0] wb_data,
      input bit           exp_fill,
      input logic [31:0]  fill_addr,
      input logic [255:0] fill_line,
      input logic [31:0]  exp_rdata,
      input int           exp_lat
   );
      int cycles;
      bit got, saw_wb, saw_fill;
      @(negedge clk);
      bus.mem_address     = addr;
      bus.mem_read        = !wr;
      bus.mem_write       = wr;
      bus.mem_byte_enable = be;
      bus.mem_wdata       = wd;
      cycles = 0; got = 0; saw_wb = 0; saw_fill = 0;
      while (!got && cycles < 40) begin
         @(negedge clk);
         cycles++;
         bus.pmem_resp = 1'b0;
         if (bus.mem_resp) begin
            got = 1;
            check({tag, "_latency"}, 256'(cycles), 256'(exp_lat));
            if (!wr) check({tag, "_rdata"}, 256'(bus.mem_rdata), 256'(exp_rdata));
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
         end else if (bus.pmem_write) begin
            saw_wb = 1;
            check({tag, "_wb_before_fill"}, 256'(saw_fill), 256'(0));
            check({tag, "_wb_addr"}, 256'(bus.pmem_address), 256'(wb_addr));
            check({tag, "_wb_data"}, bus.pmem_wdata, wb_data);
            bus.pmem_resp = 1'b1;
         end else if (bus.pmem_read) begin
            saw_fill = 1;
            check({tag, "_fill_addr"}, 256'(bus.pmem_address), 256'(fill_addr));
            bus.pmem_rdata = fill_line;
            bus.pmem_resp  = 1'b1;
         end
      end
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.pmem_resp = 1'b0;
      check({tag, "_resp_seen"}, 256'(got), 256'(1));
      check({tag, "_wb_seen"}, 256'(saw_wb), 256'(exp_wb));
      check({tag, "_fill_seen"}, 256'(saw_fill), 256'(exp_fill));
   endtask

   initial begin
      logic [255:0] line_a, line_a_mod, line_b, line_c, line_c_mod, line_d, line_e;
      int  wait_cnt;
      bit  saw_rd;
      tests = 0;
      fails = 0;

      line_a = mk_line(32'hA000_0000);
      line_a[95:64]  = 32'hDEAD_BEEF;
      line_a[127:96] = 32'hCAFE_F00D;
      line_a_mod = line_a;
      line_a_mod[95:64] = 32'hDEAD_ABEF;
      line_b = mk_line(32'hB000_0000);
      line_c = mk_line(32'hC000_0000);
      line_c_mod = line_c;
      line_c_mod[31:0] = 32'h1234_5678;
      line_d = mk_line(32'hD000_0000);
      line_e = mk_line(32'hE000_0000);

      rst = 1'b1;
      bus.mem_address = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      bus.mem_byte_enable = '0; bus.mem_wdata = '0;
      bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_state",      256'(dbg_state),        256'(0));
      check("rst_mem_resp",   256'(bus.mem_resp),     256'(0));
      check("rst_mem_rdata",  256'(bus.mem_rdata),    256'(0));
      check("rst_pmem_read",  256'(bus.pmem_read),    256'(0));
      check("rst_pmem_write", 256'(bus.pmem_write),   256'(0));
      check("rst_pmem_addr",  256'(bus.pmem_address), 256'(0));
      check("rst_pmem_wdata", bus.pmem_wdata,         256'(0));

      // Cold read miss, then hits on the same line
      access("t1_cold_rd", 32'h48, 0, 4'h0, 32'h0, 0, 32'h0, '0, 1, 32'h40, line_a, 32'hDEAD_BEEF, 3);
      access("t2_hit_rd",  32'h4C, 0, 4'h0, 32'h0, 0, 32'h0, '0, 0, 32'h0, '0, 32'hCAFE_F00D, 1);
      access("t3_hit_wr",  32'h48, 1, 4'b0010, 32'h0000_AB00, 0, 32'h0, '0, 0, 32'h0, '0, 32'h0, 1);
      access("t3_rd_back", 32'h48, 0, 4'h0, 32'h0, 0, 32'h0, '0, 0, 32'h0, '0, 32'hDEAD_ABEF, 1);

      // Conflict on dirty set 2: writeback of merged line, then fill
      access("t4_dirty_miss", 32'h140, 0, 4'h0, 32'h0, 1, 32'h40, line_a_mod, 1, 32'h140, line_b, 32'hB000_0000, 4);

      // Write miss allocates then merges; conflicting read writes it back
      access("t5_wr_miss", 32'h200, 1, 4'b1111, 32'h1234_5678, 0, 32'h0, '0, 1, 32'h200, line_c, 32'h0, 3);
      access("t5_conflict", 32'h300, 0, 4'h0, 32'h0, 1, 32'h200, line_c_mod, 1, 32'h300, line_d, 32'hD000_0000, 4);

      // Reset during ALLOCATE; the late pmem_resp must be ignored
      access("t6_refill", 32'h4C, 0, 4'h0, 32'h0, 0, 32'h0, '0, 1, 32'h40, line_a, 32'hCAFE_F00D, 3);
      @(negedge clk);
      bus.mem_address = 32'h20;
      bus.mem_read    = 1'b1;
      wait_cnt = 0; saw_rd = 0;
      while (!saw_rd && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
         if (bus.pmem_read) saw_rd = 1;
      end
      check("t6_alloc_reached", 256'(saw_rd), 256'(1));
      check("t6_alloc_addr", 256'(bus.pmem_address), 256'(32'h20));
      rst = 1'b1;
      bus.mem_read = 1'b0;
      @(negedge clk);
      check("t6_rst_pmem_read",  256'(bus.pmem_read),  256'(0));
      check("t6_rst_pmem_write", 256'(bus.pmem_write), 256'(0));
      check("t6_rst_state",      256'(dbg_state),      256'(0));
      rst = 1'b0;
      bus.pmem_rdata = line_e;
      bus.pmem_resp  = 1'b1;
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      check("t6_late_state",     256'(dbg_state),     256'(0));
      check("t6_late_mem_resp",  256'(bus.mem_resp),  256'(0));
      check("t6_late_pmem_read", 256'(bus.pmem_read), 256'(0));
      access("t6_reread", 32'h4C, 0, 4'h0, 32'h0, 0, 32'h0, '0, 1, 32'h40, line_e, 32'hE000_0003, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
